// File: rtl/sreg_pkg.sv
// Shared helpers for the sreg delay line: tap-select clamping and elaboration limits.
// Stage records are {valid, data}; each module declares stage_t from its own DATA_W.
package sreg_pkg;

  localparam int SREG_MAX_DEPTH = 64;

  // Maps a requested delay onto a tap that exists: 0 reads stage 0, oversize reads the last stage.
  function automatic int clamp_dly(input int sel, input int depth);
    if (sel < 1) begin
      return 1;
    end
    if (sel > depth) begin
      return depth;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sreg_stage.sv
// One {valid, data} register of the delay line; clear beats enable, and enable=0 holds.
// Latency 1 enabled cycle; no backpressure, the stage only moves when ce_i is high.
module sreg_stage
  import sreg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclr_i,
  input  logic              ce_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t stage_q;
  stage_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (sclr_i) begin
      stage_d = '0;
    end else if (ce_i) begin
      stage_d.valid = valid_i;
      stage_d.data  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = stage_q.valid;
  assign data_o  = stage_q.data;

endmodule

// File: rtl/sreg_delay_line.sv
// Parametrised delay line with runtime tap select, per-stage valid, fill counter and primed flag.
// Latency = clamped dly_sel enabled cycles (combinational tap mux); SREG_TAPS_EN exposes all stages on taps.
module sreg_delay_line
  import sreg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 10,
  parameter int DLY_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     sclr,
  input  logic [DATA_W-1:0]        d,
  input  logic                     d_valid,
  input  logic [DLY_W-1:0]         dly_sel,
  output logic [DATA_W-1:0]        q,
  output logic                     q_valid,
  output logic                     primed,
  output logic [DLY_W-1:0]         fill_cnt,
  output logic [DATA_W*DEPTH-1:0]  taps
);

  if (DEPTH < 1 || DEPTH > SREG_MAX_DEPTH) begin : g_bad_depth
    $error("sreg_delay_line: DEPTH out of range");
  end
  if (DLY_W < $clog2(DEPTH + 1)) begin : g_bad_dly_w
    $error("sreg_delay_line: DLY_W too narrow for DEPTH");
  end

  logic [DEPTH-1:0]  stg_valid;
  logic [DATA_W-1:0] stg_data [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      sreg_stage #(.DATA_W(DATA_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclr_i  (sclr),
        .ce_i    (ce),
        .valid_i (d_valid),
        .data_i  (d),
        .valid_o (stg_valid[k]),
        .data_o  (stg_data[k])
      );
    end else begin : g_body
      sreg_stage #(.DATA_W(DATA_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclr_i  (sclr),
        .ce_i    (ce),
        .valid_i (stg_valid[k-1]),
        .data_i  (stg_data[k-1]),
        .valid_o (stg_valid[k]),
        .data_o  (stg_data[k])
      );
    end
  end

  logic [DLY_W-1:0] eff;
  assign eff = DLY_W'(clamp_dly(int'(dly_sel), DEPTH));

  // Tap mux stays unregistered so a dly_sel change is visible in the same cycle.
  always_comb begin
    q       = '0;
    q_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (eff == DLY_W'(k + 1)) begin
        q       = stg_data[k];
        q_valid = stg_valid[k];
      end
    end
  end

  logic [DLY_W-1:0] fill_cnt_q;
  logic [DLY_W-1:0] fill_cnt_d;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (sclr) begin
      fill_cnt_d = '0;
    end else if (ce && (fill_cnt_q != DLY_W'(DEPTH))) begin
      fill_cnt_d = fill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign fill_cnt = fill_cnt_q;
  assign primed   = (fill_cnt_q >= eff);

`ifdef SREG_TAPS_EN
  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*DATA_W +: DATA_W] = stg_data[k];
  end
`else
  assign taps = '0;
`endif

endmodule

// File: tb/tb_sreg_delay_line.sv
// Directed bench for sreg_delay_line: queue-based history model checked every cycle plus literal pins.
module tb_sreg_delay_line;

  localparam int DW = 8;
  localparam int DP = 10;
  localparam int LW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ce, sclr, d_valid;
  logic [DW-1:0]  d;
  logic [LW-1:0]  dly_sel;
  logic [DW-1:0]  q;
  logic           q_valid, primed;
  logic [LW-1:0]  fill_cnt;
  logic [DW*DP-1:0] taps;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model: hist[0] is the newest accepted word, hist[k] the word written k enabled cycles ago.
  logic [DW:0] hist[$];
  int          mfill;

  sreg_delay_line #(.DATA_W(DW), .DEPTH(DP), .DLY_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .sclr     (sclr),
    .d        (d),
    .d_valid  (d_valid),
    .dly_sel  (dly_sel),
    .q        (q),
    .q_valid  (q_valid),
    .primed   (primed),
    .fill_cnt (fill_cnt),
    .taps     (taps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW*DP-1:0] act, input logic [DW*DP-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    hist.delete();
    repeat (DP) hist.push_back('0);
    mfill = 0;
  endtask

  function automatic int eff_of(input int s);
    if (s == 0) return 1;
    if (s > DP) return DP;
    return s;
  endfunction

  function automatic logic [DW*DP-1:0] exp_taps();
    logic [DW*DP-1:0] t;
    t = '0;
`ifdef SREG_TAPS_EN
    for (int k = 0; k < DP; k++) t[k*DW +: DW] = hist[k][DW-1:0];
`endif
    return t;
  endfunction

  initial begin
    mdl_clear();
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (sclr) begin
          mdl_clear();
        end else if (ce) begin
          hist.push_front({d_valid, d});
          void'(hist.pop_back());
          if (mfill < DP) mfill++;
        end
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    mdl_clear();
  end

  initial forever begin
    int e;
    @(negedge clk);
    if (chk_en) begin
      e = eff_of(int'(dly_sel));
      chk("q", q, hist[e-1][DW-1:0]);
      chk("q_valid", q_valid, hist[e-1][DW]);
      chk("primed", primed, mfill >= e);
      chk("fill_cnt", fill_cnt, mfill);
      chk("taps", taps, exp_taps());
    end
  end

  // Inputs change 2 ns after a rising edge and are consumed by the following edge.
  task automatic step(input logic c, input logic s, input logic [DW-1:0] dd, input logic v);
    @(posedge clk);
    #2;
    ce = c; sclr = s; d = dd; d_valid = v;
  endtask

  initial begin
    ce = 0; sclr = 0; d = 0; d_valid = 0; dly_sel = 4'd10;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_primed", primed, 0);
    chk("rst_fill", fill_cnt, 0);
    chk("rst_taps", taps, 0);
    rst_n = 1'b1;
    chk_en = 1;

    // Reset and latency at dly_sel=10
    for (int i = 1; i <= 12; i++) begin
      step(1, 0, DW'(i), 1);
      if (i == 10) begin
        chk("lat_q_valid_pre", q_valid, 0);
        chk("lat_primed_pre", primed, 0);
        chk("lat_fill_pre", fill_cnt, 9);
      end
      if (i == 11) begin
        chk("lat_q_first", q, 1);
        chk("lat_primed", primed, 1);
        chk("lat_fill", fill_cnt, 10);
      end
      if (i == 12) chk("lat_q_second", q, 2);
    end

    // ce gating at dly_sel=3
    step(1, 0, 8'hA5, 1);
    dly_sel = 4'd3;
    for (int h = 0; h < 5; h++) begin
      step(0, 0, DW'(8'h70 + h), 0);
      chk("hold_q", q, 8'd11);
    end
    step(1, 0, 8'h20, 1);
    chk("gate_q0", q, 8'd11);
    step(1, 0, 8'h21, 1);
    chk("gate_q1", q, 8'd12);
    step(1, 0, 8'h22, 1);
    chk("gate_q2", q, 8'hA5);

    // Runtime delay switch with ce=0
    dly_sel = 4'd10;
    for (int k = 1; k <= 10; k++) step(1, 0, DW'(k), 1);
    step(0, 0, 8'h00, 0);
    chk("sw_q_before", q, 1);
    #1 dly_sel = 4'd4;
    #1;
    chk("sw_q_after", q, 7);
    chk("sw_primed", primed, 1);

    // Clamping with a partly filled chain
    step(0, 1, 8'h00, 0);
    for (int k = 1; k <= 5; k++) step(1, 0, DW'(8'h30 + k), 1);
    step(0, 0, 8'h00, 0);
    dly_sel = 4'd0;
    #1;
    chk("clamp0_q", q, 8'h35);
    chk("clamp0_primed", primed, 1);
    chk("clamp_fill", fill_cnt, 5);
    dly_sel = 4'd15;
    #1;
    chk("clamp15_primed", primed, 0);
    chk("clamp15_q_valid", q_valid, 0);
    dly_sel = 4'd0;
    step(1, 0, 8'h40, 1);
    step(0, 0, 8'h00, 0);
    chk("clamp0_lat1", q, 8'h40);
    dly_sel = 4'd15;
    for (int k = 0; k < 12; k++) step(1, 0, DW'(8'h80 + k), 1);

    // Clear priority over ce, then a single bubble
    dly_sel = 4'd3;
    step(1, 0, 8'h50, 1);
    step(1, 0, 8'h51, 1);
    step(1, 1, 8'hFF, 1);
    step(1, 0, 8'h60, 1);
    chk("clr_fill", fill_cnt, 0);
    chk("clr_taps", taps, 0);
    chk("clr_q", q, 0);
    chk("clr_q_valid", q_valid, 0);
    step(1, 0, 8'h61, 0);
    step(1, 0, 8'h62, 1);
    step(1, 0, 8'h63, 1);
    chk("bub_q_before", q, 8'h60);
    chk("bub_v_before", q_valid, 1);
    step(1, 0, 8'h64, 1);
    chk("bub_q", q, 8'h61);
    chk("bub_v", q_valid, 0);
    step(1, 0, 8'h65, 1);
    chk("bub_v_after", q_valid, 1);

    // Asynchronous reset pulse between edges on a full chain
    dly_sel = 4'd10;
    for (int k = 1; k <= 10; k++) step(1, 0, DW'(8'h90 + k), 1);
    step(0, 0, 8'h00, 0);
    chk("ar_fill_pre", fill_cnt, 10);
    chk("ar_q_pre", q, 8'h91);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_q", q, 0);
    chk("ar_q_valid", q_valid, 0);
    chk("ar_fill", fill_cnt, 0);
    chk("ar_primed", primed, 0);
    chk("ar_taps", taps, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1, 0, DW'(8'hC0 + k), 1);
    step(0, 0, 8'h00, 0);
    chk("ar_refill", fill_cnt, 4);

    repeat (2) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
